// File: rtl/sm_display_pkg.sv
// sm_display_pkg: shared FSM states, 7-segment glyphs and decoder for the display driver
package sm_display_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  localparam logic [6:0] GLYPH [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLANK = 7'h7F;
  localparam logic [6:0] MINUS = 7'h3F;
  function automatic logic [6:0] seg7(input logic [3:0] n);
    return (n <= 4'd9) ? GLYPH[n] : BLANK;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 binary to BCD converter, one bit per cycle
module bin2bcd_seq
  import sm_display_pkg::*;
#(
  parameter int MagW = 5,
  parameter int Digits = 4
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [MagW-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*Digits-1:0]   bcd
);
  localparam int CW = $clog2(MagW + 1);
  state_t state, state_n;
  logic [MagW-1:0] sr;
  logic [4*Digits-1:0] acc, adj;
  logic [4*Digits+MagW-1:0] sh;
  logic [CW-1:0] cnt;
  for (genvar i = 0; i < Digits; i++) begin : g_adj
    assign adj[4*i+:4] = (acc[4*i+:4] >= 4'd5) ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  assign sh = {adj, sr} << 1;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = (state == IDLE) ? (start ? SHIFT : IDLE) :
              (state == SHIFT) ? ((cnt == CW'(1)) ? LOAD : SHIFT) : IDLE;
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (state == IDLE && start) begin
      sr  <= bin;
      acc <= '0;
      cnt <= CW'(MagW);
    end else if (state == SHIFT) begin
      acc <= sh[4*Digits+MagW-1:MagW];
      sr  <= sh[MagW-1:0];
      cnt <= cnt - 1'b1;
    end
  assign busy = state != IDLE;
  assign done = state == LOAD;
  assign bcd  = acc;
endmodule

// File: rtl/sm_display_driver.sv
// sm_display_driver: converts the counter value to BCD and scans it onto a
// multiplexed common-anode 7-segment display with blanking and a minus sign.
module sm_display_driver
  import sm_display_pkg::*;
#(
  parameter int    Size    = 5,
  parameter string Signed  = "No",
  parameter int    Digits  = 4,
  parameter int    ScanDiv = 50000
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [Size-1:0]   Data,
  output logic [6:0]        Segments,
  output logic [Digits-1:0] DigitSel,
  output logic              Busy
);
  localparam bit IsSigned = (Signed == "Yes");
  localparam int MagW = IsSigned ? Size - 1 : Size;
  localparam int IW = (Digits > 1) ? $clog2(Digits) : 1;
  localparam int PW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  logic [Size-1:0] last_data;
  logic neg_q, sign_q, start, done, wrap;
  logic [4*Digits-1:0] bcd;
  logic [Digits-1:0][3:0] disp;
  logic [Digits-1:0] upz;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx, idx_n;
  logic [6:0] glyph;
  assign start = !Busy && Data != last_data;
  bin2bcd_seq #(.MagW(MagW), .Digits(Digits)) u_conv (
    .Clock(Clock),
    .Reset(Reset),
    .start(start),
    .bin(Data[MagW-1:0]),
    .busy(Busy),
    .done(done),
    .bcd(bcd)
  );
  // upz[i]: every nibble from position i upward is zero, so digit i is a leading zero
  for (genvar i = 0; i < Digits; i++) begin : g_upz
    assign upz[i] = disp[Digits-1:i] == '0;
  end
  assign wrap  = pre == PW'(ScanDiv - 1);
  assign idx_n = wrap ? ((idx == IW'(Digits - 1)) ? '0 : idx + 1'b1) : idx;
  assign glyph = (IsSigned && idx_n == IW'(Digits - 1) && sign_q) ? MINUS :
                 (idx_n != '0 && upz[idx_n]) ? BLANK : seg7(disp[idx_n]);
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      last_data <= '0;
      neg_q     <= 1'b0;
      disp      <= '0;
      sign_q    <= 1'b0;
      pre       <= '0;
      idx       <= '0;
      Segments  <= GLYPH[0];
      DigitSel  <= ~Digits'(1);
    end else begin
      if (start) begin
        last_data <= Data;
        neg_q     <= IsSigned && Data[Size-1] && Data[MagW-1:0] != '0;
      end
      if (done) begin
        disp   <= bcd;
        sign_q <= neg_q;
      end
      pre      <= wrap ? '0 : pre + 1'b1;
      idx      <= idx_n;
      Segments <= glyph;
      DigitSel <= ~(Digits'(1) << idx_n);
    end
endmodule

// File: tb/tb_sm_display_driver.sv
// tb_sm_display_driver: scoreboard bench for unsigned and signed display drivers
module tb_sm_display_driver;
  logic Clock, Reset;
  logic [4:0] data_u, data_s;
  logic [6:0] seg_u, seg_s;
  logic [2:0] sel_u, sel_s;
  logic busy_u, busy_s;
  int vectors = 0;
  int miscompares = 0;
  logic [20:0] exp_q[$];

  sm_display_driver #(.Size(5), .Signed("No"), .Digits(3), .ScanDiv(4)) du (
    .Clock(Clock), .Reset(Reset), .Data(data_u),
    .Segments(seg_u), .DigitSel(sel_u), .Busy(busy_u));
  sm_display_driver #(.Size(5), .Signed("Yes"), .Digits(3), .ScanDiv(4)) ds (
    .Clock(Clock), .Reset(Reset), .Data(data_s),
    .Segments(seg_s), .DigitSel(sel_s), .Busy(busy_s));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] glyph_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // {digit2, digit1, digit0} glyphs for a magnitude and a sign flag
  function automatic logic [20:0] model(input int mag, input bit sign);
    int d0, d1, d2;
    bit neg;
    logic [6:0] g0, g1, g2;
    d0 = mag % 10;
    d1 = (mag / 10) % 10;
    d2 = mag / 100;
    neg = sign && mag != 0;
    g0 = glyph_of(d0);
    g1 = (d1 == 0 && d2 == 0) ? 7'h7F : glyph_of(d1);
    g2 = neg ? 7'h3F : (d2 == 0) ? 7'h7F : glyph_of(d2);
    return {g2, g1, g0};
  endfunction

  task automatic busy_cycles(input bit s, output int n);
    n = 0;
    @(negedge Clock);
    while ((s ? busy_s : busy_u) && n < 40) begin
      n++;
      @(negedge Clock);
    end
  endtask

  task automatic scan_read(input bit s, output logic [20:0] g);
    logic [2:0] sel;
    g = 'x;
    repeat (2) @(negedge Clock);
    repeat (12) begin
      sel = s ? sel_s : sel_u;
      for (int i = 0; i < 3; i++)
        if (sel == ~(3'b001 << i)) g[7*i+:7] = s ? seg_s : seg_u;
      @(negedge Clock);
    end
  endtask

  task automatic test_reset();
    logic [10:0] exp_o;
    int idx;
    Reset = 1'b0;
    data_u = '0;
    data_s = '0;
    repeat (3) @(negedge Clock);
    Reset = 1'b1;
    for (int k = 0; k < 24; k++) begin
      idx = (k / 4) % 3;
      exp_o = {1'b0, ~(3'b001 << idx), (idx == 0) ? 7'h40 : 7'h7F};
      vectors++;
      if ({busy_u, sel_u, seg_u} !== exp_o) begin
        miscompares++;
        $display("FAIL reset_scan_u k=%0d: got %h expected %h", k, {busy_u, sel_u, seg_u}, exp_o);
      end
      vectors++;
      if ({busy_s, sel_s, seg_s} !== exp_o) begin
        miscompares++;
        $display("FAIL reset_scan_s k=%0d: got %h expected %h", k, {busy_s, sel_s, seg_s}, exp_o);
      end
      @(negedge Clock);
    end
  endtask

  task automatic convert(input bit s, input logic [4:0] val, input int mag,
                         input bit sign, input int busy_exp, input string name);
    int n;
    logic [20:0] got, e;
    if (s) data_s = val;
    else data_u = val;
    exp_q.push_back(model(mag, sign));
    busy_cycles(s, n);
    vectors++;
    if (n !== busy_exp) begin
      miscompares++;
      $display("FAIL %s_busy: got %0d cycles expected %0d", name, n, busy_exp);
    end
    scan_read(s, got);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s_glyphs: got %h expected %h", name, got, e);
    end
  endtask

  task automatic test_unsigned();
    convert(1'b0, 5'd27, 27, 1'b0, 6, "unsigned_27");
    convert(1'b0, 5'd31, 31, 1'b0, 6, "unsigned_31");
  endtask

  task automatic test_signed();
    convert(1'b1, 5'b10011, 3, 1'b1, 5, "signed_m3");
  endtask

  task automatic test_neg_zero();
    convert(1'b1, 5'b10000, 0, 1'b1, 5, "signed_m0");
    convert(1'b1, 5'b01111, 15, 1'b0, 5, "signed_p15");
  endtask

  task automatic test_back_to_back();
    int t;
    logic [20:0] e, got;
    logic [6:0] eg;
    data_u = 5'd10;
    exp_q.push_back(model(10, 1'b0));
    @(negedge Clock);
    data_u = 5'd11;
    @(negedge Clock);
    data_u = 5'd12;
    exp_q.push_back(model(12, 1'b0));
    t = 0;
    while (busy_u && t < 40) begin
      @(negedge Clock);
      t++;
    end
    @(negedge Clock);
    e = exp_q.pop_front();
    eg = 7'hxx;
    for (int i = 0; i < 3; i++)
      if (sel_u == ~(3'b001 << i)) eg = e[7*i+:7];
    vectors++;
    if (seg_u !== eg) begin
      miscompares++;
      $display("FAIL b2b_first_10: got %h expected %h (sel %b)", seg_u, eg, sel_u);
    end
    vectors++;
    if (busy_u !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_reconvert_busy: got %b expected 1", busy_u);
    end
    t = 0;
    while (busy_u && t < 40) begin
      @(negedge Clock);
      t++;
    end
    scan_read(1'b0, got);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL b2b_final_12: got %h expected %h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [20:0] got, e;
    data_u = 5'd9;
    exp_q.push_back(model(9, 1'b0));
    repeat (2) @(negedge Clock);
    vectors++;
    if (busy_u !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy_before_reset: got %b expected 1", busy_u);
    end
    #2 Reset = 1'b0;
    #1;
    vectors++;
    if ({busy_u, sel_u, seg_u} !== {1'b0, 3'b110, 7'h40}) begin
      miscompares++;
      $display("FAIL mid_async_reset: got %h expected %h", {busy_u, sel_u, seg_u}, {1'b0, 3'b110, 7'h40});
    end
    @(negedge Clock);
    Reset = 1'b1;
    busy_cycles(1'b0, n);
    vectors++;
    if (n !== 6) begin
      miscompares++;
      $display("FAIL mid_reconvert_busy: got %0d cycles expected 6", n);
    end
    scan_read(1'b0, got);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL mid_reconvert_9: got %h expected %h", got, e);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_neg_zero();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
